// File: rtl/binary_to_rns_pkg.sv
// Shared constants, field layout and FSM state type for the binary -> (8,7,5) RNS converter.
package binary_to_rns_pkg;

  localparam int unsigned RNS_N = 280;
  localparam int unsigned MOD8  = 8;
  localparam int unsigned MOD7  = 7;
  localparam int unsigned MOD5  = 5;

  localparam int unsigned RNS_F8_HI = 8;
  localparam int unsigned RNS_F8_LO = 6;
  localparam int unsigned RNS_F7_HI = 5;
  localparam int unsigned RNS_F7_LO = 3;
  localparam int unsigned RNS_F5_HI = 2;
  localparam int unsigned RNS_F5_LO = 0;

  // Residue register width: (r<<1)|bit peaks at 2m-1 = 15 for m = 8.
  localparam int unsigned RES_W   = 4;
  localparam int unsigned FIELD_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

endpackage

// File: rtl/binary_to_rns_reducer.sv
// Serial restoring reducer: shifts one MSB-first bit per enabled cycle into a residue mod MODULUS.
module rns_mod_reducer
  import binary_to_rns_pkg::*;
#(
  parameter int unsigned MODULUS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [RES_W-1:0] residue
);

  logic [RES_W-1:0] shifted_c;
  logic [RES_W-1:0] reduced_c;

  always_comb begin
    shifted_c = {residue[RES_W-2:0], bit_in};
    reduced_c = shifted_c;
    if (shifted_c >= RES_W'(MODULUS)) begin
      reduced_c = shifted_c - RES_W'(MODULUS);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      residue <= '0;
    end else if (clear) begin
      residue <= '0;
    end else if (enable) begin
      residue <= reduced_c;
    end
  end

endmodule

// File: rtl/binary_to_rns.sv
// Unsigned binary -> (8,7,5) RNS converter, one input bit per cycle, ready/valid on both sides.
// Optional range flagging of inputs >= 280 is enabled by defining RNS_RANGE_CHECK_EN.
module binary_to_rns
  import binary_to_rns_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 9,
  parameter int unsigned N_BITS   = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_BITS-1:0]   rns,
  output logic                out_err
);

  localparam int unsigned CNT_W = $clog2(IN_WIDTH);

  state_t              state;
  state_t              state_next;
  logic                load_c;
  logic                step_c;
  logic                clear_c;
  logic [IN_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [RES_W-1:0]    res8;
  logic [RES_W-1:0]    res7;
  logic [RES_W-1:0]    res5;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load_c     = 1'b1;
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        step_c = 1'b1;
        if (cnt_q == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags follow the state being entered so they are glitch-free registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load_c) begin
      shift_q <= in_bin;
      cnt_q   <= CNT_W'(IN_WIDTH - 1);
    end else if (step_c) begin
      shift_q <= {shift_q[IN_WIDTH-2:0], 1'b0};
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

`ifdef RNS_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (load_c) begin
      err_q <= (32'(in_bin) >= RNS_N);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_err <= 1'b0;
    end else begin
      out_err <= (state_next == DONE) && err_q;
    end
  end

  // Out-of-range inputs keep the residues pinned at zero, so rns reads 0 in DONE.
  assign clear_c = load_c || err_q;
`else
  assign out_err = 1'b0;
  assign clear_c = load_c;
`endif

  rns_mod_reducer #(.MODULUS(MOD8)) u_red8 (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_c),
    .enable  (step_c),
    .bit_in  (shift_q[IN_WIDTH-1]),
    .residue (res8)
  );

  rns_mod_reducer #(.MODULUS(MOD7)) u_red7 (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_c),
    .enable  (step_c),
    .bit_in  (shift_q[IN_WIDTH-1]),
    .residue (res7)
  );

  rns_mod_reducer #(.MODULUS(MOD5)) u_red5 (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_c),
    .enable  (step_c),
    .bit_in  (shift_q[IN_WIDTH-1]),
    .residue (res5)
  );

  // Residues are held from the last REDUCE edge until the next accept, so they drive rns directly.
  assign rns[RNS_F8_HI:RNS_F8_LO] = res8[FIELD_W-1:0];
  assign rns[RNS_F7_HI:RNS_F7_LO] = res7[FIELD_W-1:0];
  assign rns[RNS_F5_HI:RNS_F5_LO] = res5[FIELD_W-1:0];

  residue_bound_a : assert property (@(posedge clock) disable iff (!reset)
    !(res8[RES_W-1] || res7[RES_W-1] || res5[RES_W-1]));

endmodule

// File: tb/tb_binary_to_rns.sv
// Self-checking bench for binary_to_rns: residues from plain modulo arithmetic, CRT-style round trip.
`timescale 1ns/1ps
module tb_binary_to_rns;

`ifdef RNS_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_bin = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] rns;
  logic       out_err;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_rns = '0;
  logic       exp_err = 1'b0;
  bit         exp_pending = 1'b0;

  binary_to_rns dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rns       (rns),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] residues(int x);
    logic [2:0] a, b, c;
    a = 3'(x % 8);
    b = 3'(x % 7);
    c = 3'(x % 5);
    return {a, b, c};
  endfunction

  function automatic logic [8:0] model_rns(int x);
    if (RANGE_EN && x >= 280) return 9'd0;
    return residues(x);
  endfunction

  function automatic int rns_decode(logic [8:0] r);
    for (int v = 0; v < 280; v++) begin
      if (residues(v) == r) return v;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Whenever a result is presented it must match the model for the accepted input.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      check("valid_expected", int'(exp_pending), 1);
      check("rns", int'(rns), int'(exp_rns));
      check("out_err", int'(out_err), int'(exp_err));
    end
  end

  task automatic convert(input int x, input int hold, output logic [8:0] got);
    int lat;
    bit seen;
    got = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid    = 1'b1;
    in_bin      = 9'(x);
    exp_rns     = model_rns(x);
    exp_err     = RANGE_EN && (x >= 280);
    exp_pending = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_bin   = 9'($urandom);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, 9);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_bin   = 9'($urandom);
      @(posedge clock);
      #1;
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
    end
    got = rns;
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready   = 1'b0;
    exp_pending = 1'b0;
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    logic [8:0] got;
    int         x;
    int         stray;

    // Pin the reference model against hand-computed residues.
    check("model_78", int'(model_rns(78)), int'(9'b110_001_011));
    check("model_279", int'(model_rns(279)), int'(9'b111_110_100));

    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_rns", int'(rns), 0);
    check("rst_out_err", int'(out_err), 0);
    @(negedge clock);
    reset = 1'b1;

    convert(78, 0, got);
    check("dir_78", int'(got), int'(9'b110_001_011));
    convert(0, 0, got);
    check("dir_0", int'(got), int'(9'b000_000_000));
    convert(3, 0, got);
    check("dir_3", int'(got), int'(9'b011_011_011));
    convert(123, 20, got);
    check("dir_123", int'(got), int'(9'b011_100_011));
    convert(279, 1, got);
    check("dir_279", int'(got), int'(9'b111_110_100));

    convert(280, 0, got);
    check("dir_280_rns", int'(got), 0);
`ifdef RNS_RANGE_CHECK_EN
    convert(511, 0, got);
    check("dir_511_rns", int'(got), 0);
`else
    convert(511, 0, got);
    check("dir_511_rns", int'(got), int'(9'b111_000_001));
`endif

    // Abort a conversion with reset four cycles into REDUCE.
    @(negedge clock);
    in_valid = 1'b1;
    in_bin   = 9'd200;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_rns", int'(rns), 0);
    check("abort_out_err", int'(out_err), 0);
    check("abort_in_ready", int'(in_ready), 0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid) stray++;
    end
    check("abort_no_result", stray, 0);
    convert(5, 0, got);
    check("dir_5", int'(got), int'(9'b101_101_000));

    // Full in-range sweep, reconstructed by residue matching.
    for (int v = 0; v < 280; v++) begin
      convert(v, 0, got);
      check("roundtrip", rns_decode(got), v);
    end

    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 511));
      convert(x, int'($urandom_range(0, 3)), got);
      check("rand", int'(got), int'(model_rns(x)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
